// File: rtl/axis_video_pkg.sv
// Shared types and constants for the AXI4-Stream video frame checker.
package axis_video_pkg;
  typedef enum logic {WAIT_SOF = 1'b0, ACTIVE = 1'b1} state_t;

  localparam int                LFSR_W      = 16;
  localparam logic [LFSR_W-1:0] LFSR_SEED   = 16'hACE1;
  localparam int                CHECKSUM_W  = 32;
  localparam int                FRAME_CNT_W = 16;
endpackage

// File: rtl/axis_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,15,13,4), reloaded with LFSR_SEED on reset.
module axis_lfsr16
  import axis_video_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  output logic [LFSR_W-1:0] state
);
  always_ff @(posedge clk) begin
    if (reset)
      state <= LFSR_SEED;
    else if (en)
      state <= {state[14:0], state[15] ^ state[14] ^ state[12] ^ state[3]};
  end
endmodule

// File: rtl/axis_video_frame_checker.sv
// AXI4-Stream video sink: checks SOF/EOL framing against IMG_WIDTH x IMG_HEIGHT and sums pixels per frame.
// Define AXIS_CHK_BACKPRESSURE_EN to throttle s_axis_tready with a pseudo-random pattern.
module axis_video_frame_checker
  import axis_video_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 1280,
  parameter int IMG_HEIGHT = 1024
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic                   s_axis_tvalid,
  input  logic                   s_axis_tuser,
  input  logic                   s_axis_tlast,
  output logic                   s_axis_tready,
  output logic                   o_frame_done,
  output logic                   o_frame_ok,
  output logic [FRAME_CNT_W-1:0] o_frame_count,
  output logic [CHECKSUM_W-1:0]  o_frame_checksum,
  output logic                   o_err_no_sof,
  output logic                   o_err_sof_early,
  output logic                   o_err_eol_early,
  output logic                   o_err_eol_missing,
  output logic                   o_err_sticky
);
  localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  state_t                state;
  logic [COL_W-1:0]      col;
  logic [ROW_W-1:0]      row;
  logic [CHECKSUM_W-1:0] acc;
  logic                  err_flag;
  logic                  live;

  // live keeps tready low during and immediately after reset
`ifdef AXIS_CHK_BACKPRESSURE_EN
  logic [LFSR_W-1:0] lfsr;
  logic              unused_lfsr;
  axis_lfsr16 u_lfsr (.clk(i_clk), .reset(i_reset), .en(1'b1), .state(lfsr));
  assign unused_lfsr   = &{1'b0, lfsr[LFSR_W-1:2]};
  assign s_axis_tready = live & (lfsr[0] | lfsr[1]);
`else
  assign s_axis_tready = live;
`endif

  logic                  beat, at_last, eol, miss, early, err_nxt;
  logic [CHECKSUM_W-1:0] acc_sum;

  always_comb begin
    beat    = s_axis_tvalid & s_axis_tready;
    acc_sum = acc + CHECKSUM_W'(s_axis_tdata);
    at_last = (col == COL_LAST);
    eol     = at_last | s_axis_tlast;
    miss    = at_last & ~s_axis_tlast;
    early   = ~at_last & s_axis_tlast;
    err_nxt = err_flag | miss | early;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state             <= WAIT_SOF;
      col               <= '0;
      row               <= '0;
      acc               <= '0;
      err_flag          <= 1'b0;
      live              <= 1'b0;
      o_frame_done      <= 1'b0;
      o_frame_ok        <= 1'b0;
      o_frame_count     <= '0;
      o_frame_checksum  <= '0;
      o_err_no_sof      <= 1'b0;
      o_err_sof_early   <= 1'b0;
      o_err_eol_early   <= 1'b0;
      o_err_eol_missing <= 1'b0;
      o_err_sticky      <= 1'b0;
    end else begin
      live              <= 1'b1;
      o_frame_done      <= 1'b0;
      o_err_no_sof      <= 1'b0;
      o_err_sof_early   <= 1'b0;
      o_err_eol_early   <= 1'b0;
      o_err_eol_missing <= 1'b0;
      if (beat) begin
        case (state)
          WAIT_SOF: begin
            if (s_axis_tuser) begin
              acc      <= CHECKSUM_W'(s_axis_tdata);
              col      <= COL_W'(1);
              row      <= '0;
              err_flag <= 1'b0;
              state    <= ACTIVE;
            end else begin
              o_err_no_sof <= 1'b1;
              o_err_sticky <= 1'b1;
            end
          end
          ACTIVE: begin
            if (s_axis_tuser) begin
              // Early SOF abandons the current frame and restarts on this pixel
              o_err_sof_early <= 1'b1;
              o_err_sticky    <= 1'b1;
              acc             <= CHECKSUM_W'(s_axis_tdata);
              col             <= COL_W'(1);
              row             <= '0;
              err_flag        <= 1'b0;
            end else begin
              o_err_eol_missing <= miss;
              o_err_eol_early   <= early;
              if (miss | early) o_err_sticky <= 1'b1;
              err_flag <= err_nxt;
              acc      <= acc_sum;
              if (eol) begin
                col <= '0;
                if (row == ROW_LAST) begin
                  row              <= '0;
                  state            <= WAIT_SOF;
                  o_frame_done     <= 1'b1;
                  o_frame_ok       <= ~err_nxt;
                  o_frame_count    <= o_frame_count + FRAME_CNT_W'(1);
                  o_frame_checksum <= acc_sum;
                end else begin
                  row <= row + ROW_W'(1);
                end
              end else begin
                col <= col + COL_W'(1);
              end
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_axis_video_frame_checker.sv
// Self-checking bench for axis_video_frame_checker on an 8x4 image.
module tb_axis_video_frame_checker;
  localparam int DW = 8, IW = 8, IH = 4;

  logic          i_clk = 1'b0, i_reset = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0, s_axis_tuser = 1'b0, s_axis_tlast = 1'b0;
  logic          s_axis_tready, o_frame_done, o_frame_ok, o_err_sticky;
  logic [15:0]   o_frame_count;
  logic [31:0]   o_frame_checksum;
  logic          o_err_no_sof, o_err_sof_early, o_err_eol_early, o_err_eol_missing;

  always #5 i_clk = ~i_clk;

  axis_video_frame_checker #(.DATA_WIDTH(DW), .IMG_WIDTH(IW), .IMG_HEIGHT(IH)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .o_frame_done(o_frame_done), .o_frame_ok(o_frame_ok), .o_frame_count(o_frame_count),
    .o_frame_checksum(o_frame_checksum), .o_err_no_sof(o_err_no_sof),
    .o_err_sof_early(o_err_sof_early), .o_err_eol_early(o_err_eol_early),
    .o_err_eol_missing(o_err_eol_missing), .o_err_sticky(o_err_sticky));

  // err bits: {no_sof, sof_early, eol_early, eol_missing}
  typedef struct {
    logic [7:0]  data;
    logic        user, last;
    logic [3:0]  err;
    logic        done, ok;
    logic [31:0] sum;
  } vec_t;
  typedef struct {
    logic        ok;
    logic [15:0] cnt;
    logic [31:0] sum;
  } res_t;

  vec_t        vq[$];
  res_t        sbq[$];
  int          checks = 0, failures = 0;
  logic [15:0] exp_cnt = '0;
  bit          gap = 1'b0;
  wire  [3:0]  errs = {o_err_no_sof, o_err_sof_early, o_err_eol_early, o_err_eol_missing};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] d, input logic u, input logic l, input logic [3:0] e,
                     input logic dn, input logic ok, input logic [31:0] s);
    vec_t v;
    v.data = d; v.user = u; v.last = l; v.err = e; v.done = dn; v.ok = ok; v.sum = s;
    vq.push_back(v);
  endtask

  task automatic add_clean();
    for (int i = 0; i < 32; i++)
      add(8'(i), i == 0, (i % 8) == 7, 4'b0, i == 31, 1'b1, 32'd496);
  endtask

  task automatic send(input vec_t v);
    bit r;
    int n;
    n = 0;
    s_axis_tdata = v.data; s_axis_tuser = v.user; s_axis_tlast = v.last; s_axis_tvalid = 1'b1;
    do begin
      @(negedge i_clk); r = s_axis_tready;
      @(posedge i_clk); n++;
    end while (!r && n < 64);
    if (!r) begin
      checks++; failures++;
      $display("FAIL tready_timeout: got 0 expected 1");
    end
    if (v.done) begin
      exp_cnt++;
      sbq.push_back('{v.ok, exp_cnt, v.sum});
    end
    #1;
    chk("err_pulses", 32'(errs), 32'(v.err));
    chk("frame_done_timing", 32'(o_frame_done), 32'(v.done));
    if (gap) begin
      s_axis_tvalid = 1'b0;
      @(posedge i_clk); #1;
      chk("gap_quiet", 32'({errs, o_frame_done}), 32'd0);
    end
  endtask

  task automatic run_vecs();
    for (int i = 0; i < vq.size(); i++) send(vq[i]);
    vq.delete();
    s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge i_clk); #1;
    i_reset = 1'b1; s_axis_tvalid = 1'b0;
    @(posedge i_clk); #1;
    chk("rst_tready", 32'(s_axis_tready), 0);
    chk("rst_done_ok", 32'({o_frame_done, o_frame_ok}), 0);
    chk("rst_count", 32'(o_frame_count), 0);
    chk("rst_checksum", o_frame_checksum, 0);
    chk("rst_errs", 32'({errs, o_err_sticky}), 0);
    chk("rst_sb_empty", sbq.size(), 0);
    i_reset = 1'b0;
    exp_cnt = '0;
  endtask

  always @(negedge i_clk) begin
    res_t e;
    if (o_frame_done === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_frame_done: count=%0d checksum=%0d", o_frame_count, o_frame_checksum);
      end else begin
        e = sbq.pop_front();
        chk("frame_ok", 32'(o_frame_ok), 32'(e.ok));
        chk("frame_count", 32'(o_frame_count), 32'(e.cnt));
        chk("frame_checksum", o_frame_checksum, e.sum);
      end
    end
  end

  initial begin
    do_reset();

    // clean frame, then a second one back to back
    add_clean(); run_vecs();
    chk("clean_sticky", 32'(o_err_sticky), 0);
    add_clean(); run_vecs();
    chk("count_two", 32'(o_frame_count), 2);
    do_reset();

    // alternate idle cycles between beats
    gap = 1'b1; add_clean(); run_vecs(); gap = 1'b0;
    do_reset();

    // tlast at row 1 col 5: 30 pixels 0..29
    for (int i = 0; i < 30; i++)
      add(8'(i), i == 0, (i == 7) || (i == 13) || (i == 21) || (i == 29),
          (i == 13) ? 4'b0010 : 4'b0, i == 29, 1'b0, 32'd435);
    run_vecs();
    chk("eol_early_sticky", 32'(o_err_sticky), 1);
    chk("eol_early_ok_held", 32'(o_frame_ok), 0);
    do_reset();

    // no tlast at column 7 of row 0
    add_clean();
    vq[7].last = 1'b0; vq[7].err = 4'b0001; vq[31].ok = 1'b0;
    run_vecs();
    chk("eol_missing_sticky", 32'(o_err_sticky), 1);
    do_reset();

    // tuser at row 2 col 3, then clean frame
    for (int i = 0; i < 19; i++) add(8'(200 + i), i == 0, (i % 8) == 7, 4'b0, 1'b0, 1'b0, 0);
    add_clean();
    vq[19].err = 4'b0100;
    run_vecs();
    chk("sof_early_sticky", 32'(o_err_sticky), 1);
    do_reset();

    // three beats before any SOF
    for (int i = 0; i < 3; i++) add(8'hA0 + 8'(i), 1'b0, 1'b0, 4'b1000, 1'b0, 1'b0, 0);
    add_clean(); run_vecs();
    do_reset();

    // reset at pixel 17 discards the partial frame
    for (int i = 0; i < 17; i++) add(8'(i + 50), i == 0, (i % 8) == 7, 4'b0, 1'b0, 1'b0, 0);
    run_vecs();
    do_reset();
    add_clean(); run_vecs();
    chk("final_count", 32'(o_frame_count), 1);

    chk("sb_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
